// File: rtl/axil_ram_pkg.sv
// axil_ram_pkg: response codes, FSM state types and slot-index width helper for axil_ram
package axil_ram_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} write_state_t;
  typedef enum logic {R_IDLE, R_VALID} read_state_t;
  function automatic int slot_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axil_ram_if.sv
// axil_ram_if: AXI4-Lite AW/W/B/AR/R channel bundle; master drives valids/addr/data/readies-for-responses, slave the rest
interface axil_ram_if #(parameter int ADDR_WIDTH = 8, parameter int DATA_WIDTH_BYTES = 4);
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [ADDR_WIDTH-1:0] awaddr, araddr;
  logic [DATA_WIDTH_BYTES*8-1:0] wdata, rdata;
  logic [DATA_WIDTH_BYTES-1:0] wstrb;
  logic [1:0] bresp, rresp;
  modport master(output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
                 input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
  modport slave(input awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
                output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
endinterface

// File: rtl/strb_ram_array.sv
// strb_ram_array: NUM_SLOTS x DATA_WIDTH_BYTES storage, byte-strobed write port, registered read port (rok=0 reads 0), sync clear on rst
module strb_ram_array import axil_ram_pkg::*; #(
  parameter int NUM_SLOTS = 6,
  parameter int DATA_WIDTH_BYTES = 4,
  localparam int SW = slot_w(NUM_SLOTS)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [SW-1:0] waddr,
  input  logic [DATA_WIDTH_BYTES*8-1:0] wdata,
  input  logic [DATA_WIDTH_BYTES-1:0] wstrb,
  input  logic re,
  input  logic rok,
  input  logic [SW-1:0] raddr,
  output logic [DATA_WIDTH_BYTES*8-1:0] rdata
);
  logic [DATA_WIDTH_BYTES-1:0][7:0] mem [NUM_SLOTS];
  always_ff @(posedge clk)
    if (rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) mem[k] <= '0;
      rdata <= '0;
    end else begin
      if (we) for (int i = 0; i < DATA_WIDTH_BYTES; i++) if (wstrb[i]) mem[waddr][i] <= wdata[i*8 +: 8];
      if (re) rdata <= rok ? mem[raddr] : '0;
    end
endmodule

// File: rtl/axil_ram.sv
// axil_ram: AXI4-Lite slave RAM (clk, rst, s: axil_ram_if.slave); strobe-merge writes, registered reads, SLVERR beyond NUM_SLOTS
module axil_ram import axil_ram_pkg::*; #(
  parameter int NUM_SLOTS = 6,
  parameter int DATA_WIDTH_BYTES = 4,
  parameter int ADDR_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  axil_ram_if.slave s
);
  localparam int OB = $clog2(DATA_WIDTH_BYTES);
  localparam int SW = slot_w(NUM_SLOTS);
  localparam int DW = DATA_WIDTH_BYTES * 8;
  write_state_t ws;
  read_state_t rs;
  logic [ADDR_WIDTH-1:0] aw_slot, ar_slot, h_slot, c_slot;
  logic [DW-1:0] h_data, c_data;
  logic [DATA_WIDTH_BYTES-1:0] h_strb, c_strb;
  logic aw_hs, w_hs, ar_hs, commit, c_ok, ar_ok;
  assign s.awready = !rst && (ws == W_IDLE || ws == W_DATA);
  assign s.wready = !rst && (ws == W_IDLE || ws == W_ADDR);
  assign s.bvalid = !rst && ws == W_RESP;
  assign s.arready = !rst && rs == R_IDLE;
  assign s.rvalid = !rst && rs == R_VALID;
  assign aw_hs = s.awvalid && s.awready;
  assign w_hs = s.wvalid && s.wready;
  assign ar_hs = s.arvalid && s.arready;
  assign aw_slot = s.awaddr >> OB;
  assign ar_slot = s.araddr >> OB;
  assign c_slot = ws == W_ADDR ? h_slot : aw_slot;
  assign c_data = ws == W_DATA ? h_data : s.wdata;
  assign c_strb = ws == W_DATA ? h_strb : s.wstrb;
  assign commit = (aw_hs && (w_hs || ws == W_DATA)) || (w_hs && ws == W_ADDR);
  assign c_ok = 32'(c_slot) < NUM_SLOTS;
  assign ar_ok = 32'(ar_slot) < NUM_SLOTS;
  always_ff @(posedge clk)
    if (rst) begin
      ws <= W_IDLE;
      s.bresp <= RESP_OKAY;
    end else begin
      if (aw_hs) h_slot <= aw_slot;
      if (w_hs) begin
        h_data <= s.wdata;
        h_strb <= s.wstrb;
      end
      if (commit) begin
        ws <= W_RESP;
        s.bresp <= c_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (ws == W_RESP && s.bready) ws <= W_IDLE;
      else if (aw_hs) ws <= W_ADDR;
      else if (w_hs) ws <= W_DATA;
    end
  always_ff @(posedge clk)
    if (rst) begin
      rs <= R_IDLE;
      s.rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      rs <= R_VALID;
      s.rresp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rs == R_VALID && s.rready) rs <= R_IDLE;
  strb_ram_array #(.NUM_SLOTS(NUM_SLOTS), .DATA_WIDTH_BYTES(DATA_WIDTH_BYTES)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(commit && c_ok),
    .waddr(c_slot[SW-1:0]),
    .wdata(c_data),
    .wstrb(c_strb),
    .re(ar_hs),
    .rok(ar_ok),
    .raddr(ar_slot[SW-1:0]),
    .rdata(s.rdata)
  );
endmodule

// File: tb/tb_axil_ram.sv
// tb_axil_ram: scoreboard bench for axil_ram
module tb_axil_ram;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  axil_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH_BYTES(4)) bus ();
  axil_ram #(.NUM_SLOTS(6), .DATA_WIDTH_BYTES(4), .ADDR_WIDTH(8)) dut (.clk(clk), .rst(rst), .s(bus));
  int n_chk = 0, n_fail = 0;
  logic [31:0] model [6];
  logic [1:0] bq [$];
  logic [33:0] rq [$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) check("b_unexpected", bus.bvalid, 0);
        else check("bresp", bus.bresp, bq.pop_front());
      end
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) check("r_unexpected", bus.rvalid, 0);
        else begin
          check("rdata", bus.rdata, rq[0][33:2]);
          check("rresp", bus.rresp, rq[0][1:0]);
          void'(rq.pop_front());
        end
      end
    end
  task automatic send_aw(input logic [7:0] a, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    bus.awvalid = 1;
    bus.awaddr = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.awready) break;
      check("b_early", bus.bvalid, 0);
    end
    check("aw_ready", bus.awready, 1);
    @(posedge clk);
    #1 bus.awvalid = 0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] st, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    bus.wvalid = 1;
    bus.wdata = d;
    bus.wstrb = st;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wready) break;
      check("b_early", bus.bvalid, 0);
    end
    check("w_ready", bus.wready, 1);
    @(posedge clk);
    #1 bus.wvalid = 0;
  endtask
  task automatic write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st, input int aw_dly, input int w_dly);
    int sl = int'(a >> 2);
    bq.push_back(sl < 6 ? 2'b00 : 2'b10);
    if (sl < 6) for (int i = 0; i < 4; i++) if (st[i]) model[sl][i*8 +: 8] = d[i*8 +: 8];
    fork
      send_aw(a, aw_dly);
      send_w(d, st, w_dly);
    join
    @(negedge clk);
    check("b_latency", bus.bvalid, 1);
    if (bus.bready) begin @(posedge clk); #1; end
  endtask
  task automatic read(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er);
    rq.push_back({ed, er});
    bus.arvalid = 1;
    bus.araddr = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.arready) break;
    end
    check("ar_ready", bus.arready, 1);
    @(posedge clk);
    #1 bus.arvalid = 0;
    @(negedge clk);
    check("r_latency", bus.rvalid, 1);
    if (bus.rready) begin @(posedge clk); #1; end
  endtask
  task automatic read_m(input logic [7:0] a);
    int sl = int'(a >> 2);
    read(a, sl < 6 ? model[sl] : 32'h0, sl < 6 ? 2'b00 : 2'b10);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    {bus.awvalid, bus.wvalid, bus.arvalid} = '0;
    {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb} = '0;
    bus.bready = 1;
    bus.rready = 1;
    foreach (model[k]) model[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_rdata", bus.rdata, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rel_awready", bus.awready, 1);
    check("rel_wready", bus.wready, 1);
    check("rel_arready", bus.arready, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) read_m(8'(k * 4));
    write(8'h08, 32'hAABBCCDD, 4'hF, 0, 0);
    write(8'h08, 32'h11223344, 4'b0101, 0, 0);
    read(8'h08, 32'hAA22CC44, 2'b00);
    write(8'h04, 32'h12345678, 4'hF, 0, 2);
    read(8'h04, 32'h12345678, 2'b00);
    write(8'h04, 32'h9ABCDEF0, 4'hF, 2, 0);
    read(8'h04, 32'h9ABCDEF0, 2'b00);
    write(8'h08, 32'h55555555, 4'h0, 0, 0);
    read(8'h08, 32'hAA22CC44, 2'b00);
    write(8'h18, 32'hFFFFFFFF, 4'hF, 0, 0);
    read(8'h1C, 32'h0, 2'b10);
    for (int k = 0; k < 6; k++) read_m(8'(k * 4));
    bus.bready = 0;
    write(8'h00, 32'hCAFEF00D, 4'hF, 0, 0);
    repeat (5) begin
      @(negedge clk);
      check("bp_bvalid", bus.bvalid, 1);
      check("bp_bresp", bus.bresp, 2'b00);
      check("bp_awready", bus.awready, 0);
      check("bp_wready", bus.wready, 0);
    end
    @(posedge clk);
    #1 bus.bready = 1;
    @(posedge clk);
    #1 bus.rready = 0;
    read(8'h00, 32'hCAFEF00D, 2'b00);
    repeat (5) begin
      @(negedge clk);
      check("bp_rvalid", bus.rvalid, 1);
      check("bp_rdata", bus.rdata, 32'hCAFEF00D);
      check("bp_rresp", bus.rresp, 2'b00);
      check("bp_arready", bus.arready, 0);
    end
    @(posedge clk);
    #1 bus.rready = 1;
    @(posedge clk);
    #1;
    write(8'h0C, 32'h5, 4'hF, 0, 0);
    fork
      write(8'h0C, 32'h9, 4'hF, 0, 0);
      read(8'h0C, 32'h5, 2'b00);
    join
    read(8'h0C, 32'h9, 2'b00);
    write(8'h10, 32'h77, 4'hF, 0, 0);
    read_m(8'h10);
    bus.awvalid = 1;
    bus.awaddr = 8'h10;
    @(negedge clk);
    check("mid_awready", bus.awready, 1);
    @(posedge clk);
    #1 bus.awvalid = 0;
    rst = 1;
    bus.wvalid = 1;
    bus.wdata = 32'hDEADBEEF;
    bus.wstrb = 4'hF;
    @(negedge clk);
    check("mid_wready", bus.wready, 0);
    check("mid_bvalid", bus.bvalid, 0);
    @(posedge clk);
    #1 rst = 0;
    bus.wvalid = 0;
    foreach (model[k]) model[k] = '0;
    repeat (3) begin
      @(negedge clk);
      check("post_bvalid", bus.bvalid, 0);
    end
    @(posedge clk);
    #1;
    read_m(8'h10);
    write(8'h14, 32'h1234, 4'b0011, 1, 0);
    read_m(8'h10);
    read_m(8'h14);
    check("bq_empty", bq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_ram.md
# axil_ram

AXI4-Lite slave wrapping a parametrised, byte-strobed RAM array. It succeeds the bare-port RAM: independent AW/W/B and AR/R channels with valid/ready handshakes, a registered read path, strobe-merge writes (unstrobed bytes keep their old value) and SLVERR for out-of-range slots. It sits between the AXI-Lite interconnect and local storage in the RAM subsystem.

## Interface
- NUM_SLOTS, 6, number of words stored; any value ≥ 1, not required to be a power of two
- DATA_WIDTH_BYTES, 4, word width in bytes; must be a power of two
- ADDR_WIDTH, 8, byte-address width of awaddr/araddr
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- awvalid / awready  in / out  1 / 1  write-address handshake
- awaddr  in  ADDR_WIDTH  write byte address
- wvalid / wready  in / out  1 / 1  write-data handshake
- wdata  in  DATA_WIDTH_BYTES*8  write data
- wstrb  in  DATA_WIDTH_BYTES  byte enables
- bvalid / bready  out / in  1 / 1  write-response handshake
- bresp  out  2  write response
- arvalid / arready  in / out  1 / 1  read-address handshake
- araddr  in  ADDR_WIDTH  read byte address
- rvalid / rready  out / in  1 / 1  read-data handshake
- rdata  out  DATA_WIDTH_BYTES*8  read data
- rresp  out  2  read response

## Operation
- Slot = addr >> log2(DATA_WIDTH_BYTES); low byte-offset bits ignored (no unaligned access).
- Slot ≥ NUM_SLOTS: response SLVERR (2'b10), write dropped, rdata = 0. Otherwise OKAY (2'b00).
- Write FSM: W_IDLE, W_ADDR (address held), W_DATA (data held), W_RESP.
  - awready = 1 in W_IDLE/W_DATA; wready = 1 in W_IDLE/W_ADDR; both 0 in W_RESP.
  - AW and W accepted in either order or the same cycle; each is latched when accepted.
  - The edge completing the second handshake commits the write and enters W_RESP.
  - W_RESP: bvalid = 1, bresp stable, until bready; then W_IDLE.
- Commit: for each byte i, mem[slot][i] = wstrb[i] ? wdata byte i : old byte. wstrb = 0 is legal (OKAY, no change).
- Read FSM: R_IDLE (arready = 1), R_VALID (rvalid = 1, arready = 0).
  - AR handshake edge registers rdata/rresp and enters R_VALID; hold until rready, then R_IDLE.
- Write and read channels are fully independent; both may handshake in the same cycle.

## Timing
- Reset (rst high at an edge): all memory words cleared to 0; FSMs → W_IDLE/R_IDLE; bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0.
- All ready/valid outputs are forced to 0 while rst is high. The first cycle after release has awready = wready = arready = 1.
- Reset mid-transaction: held address/data and any pending response are discarded; no partial write.
- Write latency: bvalid rises the cycle after the final AW/W handshake. Minimum back-to-back write is 2 cycles (bready tied high).
- Read latency: rvalid rises 1 cycle after the AR handshake. Minimum back-to-back read is 2 cycles.
- Same-slot read and write committing at the same edge: read returns the pre-write value (read-before-write).
- A later read observes any write whose commit edge preceded its AR handshake edge.
- Backpressure: bresp, rdata and rresp remain stable while their valid is high and ready is low.

## Structure
- Package axil_ram_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - write_state_t and read_state_t enums
  - slot-index width function for NUM_SLOTS / DATA_WIDTH_BYTES
- Sub-module strb_ram_array: NUM_SLOTS × DATA_WIDTH_BYTES storage.
  - One strobed write port and one registered read port, with synchronous clear on rst.
  - Range check stays in axil_ram.

## Test plan
- Reset, then read slots 0–5 → each returns rdata = 0, rresp = OKAY, rvalid one cycle after the AR handshake.
- Write slot 2 = 0xAABBCCDD with wstrb = 4'hF, then write 0x11223344 with wstrb = 4'b0101 → read slot 2 = 0xAA22CC44.
- AW two cycles before W, and separately W before AW, to slot 1 → one commit each time, bvalid one cycle after the later handshake, bresp = OKAY.
- Write to awaddr = 0x18 (slot 6) and read from araddr = 0x1C (slot 7) → bresp = SLVERR, no slot changed; rresp = SLVERR, rdata = 0.
- Hold bready/rready low for 5 cycles → valid, bresp, rdata and rresp all stable; awready/wready/arready held at 0.
- Slot 3 holds 0x5; same-edge commit of 0x9 to slot 3 and AR of slot 3 → rdata = 0x5, then next read = 0x9. Assert rst during W_ADDR → no commit, bvalid stays 0.
